// File: rtl/door_sec_pkg.sv
// Shared types, widths and the password-bank slice helper for the door security block.
package door_sec_pkg;

  localparam int DIGIT_W   = 4;
  localparam int PW_W      = 16;
  localparam int USER_W    = 4;
  localparam int MAX_USERS = (1 << USER_W) - 1;
  localparam int BANK_W    = MAX_USERS * PW_W;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    GRANT,
    DENY,
    LOCKOUT
  } state_t;

  // Bank is zero-padded to the widest id range; id 0 has no slot.
  function automatic logic [PW_W-1:0] pw_slice(input logic [BANK_W-1:0] bank,
                                               input logic [USER_W-1:0] id);
    logic [PW_W-1:0] slice;
    slice = '0;
    if (id != '0) slice = bank[(int'(id) - 1) * PW_W +: PW_W];
    return slice;
  endfunction

endpackage

// File: rtl/door_countdown.sv
// Loadable down-counter that saturates at zero; shared by the unlock and lockout windows.
module door_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/password_verify.sv
// Latches a keypad entry on an enter press, checks it against the user's stored
// password, then holds unlock, pulses deny, or enters a timed lockout.
module password_verify
  import door_sec_pkg::*;
#(
  parameter int NUM_USERS     = 10,
  parameter int MAX_FAILS     = 3,
  parameter int UNLOCK_CYCLES = 50_000_000,
  parameter int LOCK_CYCLES   = 500_000_000,
  localparam int FW           = $clog2(MAX_FAILS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enter,
  input  logic [USER_W-1:0]         user_id,
  input  logic [DIGIT_W-1:0]        digit4,
  input  logic [DIGIT_W-1:0]        digit3,
  input  logic [DIGIT_W-1:0]        digit2,
  input  logic [DIGIT_W-1:0]        digit1,
  input  logic [NUM_USERS*PW_W-1:0] stored_pw,
  output logic                      unlock,
  output logic                      deny,
  output logic                      locked,
  output logic [FW-1:0]             fail_cnt,
  output logic                      busy
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t            state;
  logic              enter_q;
  logic [USER_W-1:0] id_lat;
  logic [PW_W-1:0]   entry;
  logic [BANK_W-1:0] bank_ext;
  logic              id_valid;
  logic              match;
  logic [FW:0]       fail_next;
  logic              lock_hit;
  logic              timer_load;
  logic              timer_dec;
  logic [TW-1:0]     timer_load_value;
  logic [TW-1:0]     timer_value;
  logic              timer_zero;

  generate
    if (NUM_USERS < MAX_USERS) begin : g_pad
      assign bank_ext = {{((MAX_USERS - NUM_USERS) * PW_W){1'b0}}, stored_pw};
    end else begin : g_full
      assign bank_ext = stored_pw;
    end
  endgenerate

  assign id_valid  = (id_lat != '0) && (int'(id_lat) <= NUM_USERS);
  assign match     = id_valid && (pw_slice(bank_ext, id_lat) == entry);
  assign fail_next = {1'b0, fail_cnt} + 1'b1;
  assign lock_hit  = (fail_next == (FW+1)'(MAX_FAILS));

  // Only GRANT and LOCKOUT use the timer, so a denial leaves it untouched.
  assign timer_load       = (state == CHECK) && (match || lock_hit);
  assign timer_load_value = match ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCK_CYCLES - 1);
  assign timer_dec        = (state == GRANT) || (state == LOCKOUT);

  door_countdown #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .dec       (timer_dec),
    .load_value(timer_load_value),
    .value     (timer_value),
    .zero      (timer_zero)
  );

  // enter_q resets high so a button held through reset release is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      enter_q  <= 1'b1;
      id_lat   <= '0;
      entry    <= '0;
      unlock   <= 1'b0;
      deny     <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      enter_q <= enter;
      unique case (state)
        IDLE: begin
          if (enter && !enter_q) begin
            id_lat <= user_id;
            entry  <= {digit4, digit3, digit2, digit1};
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (match) begin
            fail_cnt <= '0;
            unlock   <= 1'b1;
            state    <= GRANT;
          end else if (lock_hit) begin
            fail_cnt <= FW'(MAX_FAILS);
            locked   <= 1'b1;
            state    <= LOCKOUT;
          end else begin
            fail_cnt <= fail_next[FW-1:0];
            deny     <= 1'b1;
            state    <= DENY;
          end
        end
        GRANT: begin
          if (timer_zero) begin
            unlock <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        DENY: begin
          deny  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        LOCKOUT: begin
          if (timer_zero) begin
            locked   <= 1'b0;
            fail_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_password_verify.sv
// Self-checking bench for password_verify: randomized attempts against an outcome model.
module tb_password_verify;

  localparam int NU = 10;
  localparam int MF = 3;
  localparam int UC = 4;
  localparam int LC = 8;
  localparam int W  = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enter = 1'b0;
  logic [3:0]       user_id = '0;
  logic [3:0]       digit4 = '0, digit3 = '0, digit2 = '0, digit1 = '0;
  logic [NU*16-1:0] stored_pw;
  logic             unlock, deny, locked, busy;
  logic [1:0]       fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int model_fail = 0;

  password_verify #(
    .NUM_USERS(NU), .MAX_FAILS(MF), .UNLOCK_CYCLES(UC), .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .user_id(user_id),
    .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .stored_pw(stored_pw), .unlock(unlock), .deny(deny), .locked(locked),
    .fail_cnt(fail_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // User u's password is the four decimal digits of u.
  function automatic logic [15:0] bank_pw(input int u);
    return {4'(u / 1000 % 10), 4'(u / 100 % 10), 4'(u / 10 % 10), 4'(u % 10)};
  endfunction

  task automatic make_wrong(output logic [3:0] id, output logic [15:0] pw);
    id = 4'($urandom_range(1, NU));
    pw = 16'($urandom_range(0, 65535));
    if (pw == bank_pw(int'(id))) pw = pw ^ 16'h0001;
  endtask

  // One press, then watch W negedges; expected traces come from the outcome rules.
  task automatic attempt(input string tag, input logic [3:0] id, input logic [15:0] pw,
                         input int hold, input int inj);
    int outc;
    int exp_fc2;
    logic [W-1:0] eu, ed, el, gu, gd, gl;
    logic gb1;
    logic [1:0] gfc2;
    eu = '0; ed = '0; el = '0; gu = '0; gd = '0; gl = '0; gb1 = 1'b0; gfc2 = '0;
    if (id >= 1 && id <= NU && pw == bank_pw(int'(id))) outc = 0;
    else if (model_fail + 1 == MF) outc = 2;
    else outc = 1;
    case (outc)
      0: begin
        for (int k = 2; k < 2 + UC; k++) eu[k] = 1'b1;
        model_fail = 0;
        exp_fc2 = 0;
      end
      1: begin
        ed[2] = 1'b1;
        model_fail = model_fail + 1;
        exp_fc2 = model_fail;
      end
      default: begin
        for (int k = 2; k < 2 + LC; k++) el[k] = 1'b1;
        model_fail = 0;
        exp_fc2 = MF;
      end
    endcase
    enter = 1'b1;
    user_id = id;
    {digit4, digit3, digit2, digit1} = pw;
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      gu[k] = unlock; gd[k] = deny; gl[k] = locked;
      if (k == 1) gb1 = busy;
      if (k == 2) gfc2 = fail_cnt;
      if (k == hold) enter = 1'b0;
      if (inj != 0 && k == inj) begin
        enter = 1'b1; user_id = 4'd1; {digit4, digit3, digit2, digit1} = bank_pw(1);
      end
      if (inj != 0 && k == inj + 1) enter = 1'b0;
    end
    $display("attempt %s id=%0d pw=%h outcome=%0d fail_cnt=%0d", tag, id, pw, outc, fail_cnt);
    n_checks++; if (gu !== eu) begin n_fail++; $display("FAIL %s unlock trace got %b exp %b", tag, gu, eu); end
    n_checks++; if (gd !== ed) begin n_fail++; $display("FAIL %s deny trace got %b exp %b", tag, gd, ed); end
    n_checks++; if (gl !== el) begin n_fail++; $display("FAIL %s locked trace got %b exp %b", tag, gl, el); end
    n_checks++; if (gb1 !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_press got %b exp 1", tag, gb1); end
    n_checks++; if (gfc2 !== 2'(exp_fc2)) begin n_fail++; $display("FAIL %s fail_cnt_at_result got %0d exp %0d", tag, gfc2, exp_fc2); end
    n_checks++; if (fail_cnt !== 2'(model_fail)) begin n_fail++; $display("FAIL %s fail_cnt_end got %0d exp %0d", tag, fail_cnt, model_fail); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_end got %b exp 0", tag, busy); end
    enter = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset unlock=%b deny=%b locked=%b fail_cnt=%0d busy=%b", unlock, deny, locked, fail_cnt, busy);
    n_checks++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL reset_unlock got %b exp 0", unlock); end
    n_checks++; if (deny !== 1'b0) begin n_fail++; $display("FAIL reset_deny got %b exp 0", deny); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
    n_checks++; if (fail_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_fail_cnt got %0d exp 0", fail_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    model_fail = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_grant();
    attempt("grant_u1", 4'd1, bank_pw(1), 1, 0);
    attempt("grant_u10", 4'd10, bank_pw(10), 1, 0);
  endtask

  task automatic test_deny();
    attempt("deny_u2", 4'd2, bank_pw(1), 1, 0);
  endtask

  task automatic test_lockout();
    logic [3:0] id;
    logic [15:0] pw;
    attempt("lock_clear", 4'd3, bank_pw(3), 1, 0);
    make_wrong(id, pw); attempt("lock_wrong1", id, pw, 1, 0);
    make_wrong(id, pw); attempt("lock_wrong2", id, pw, 1, 0);
    make_wrong(id, pw); attempt("lock_wrong3", id, pw, 1, 4);
  endtask

  task automatic test_invalid_id();
    attempt("invalid_id0", 4'd0, bank_pw(1), 1, 0);
    attempt("invalid_id11", 4'd11, bank_pw(1), 1, 0);
  endtask

  task automatic test_recover();
    logic [3:0] id;
    logic [15:0] pw;
    attempt("recover_clear", 4'd5, bank_pw(5), 1, 0);
    make_wrong(id, pw); attempt("recover_wrong1", id, pw, 1, 0);
    make_wrong(id, pw); attempt("recover_wrong2", id, pw, 1, 0);
    attempt("recover_ok", 4'd7, bank_pw(7), 1, 0);
  endtask

  task automatic test_random();
    logic [3:0] id;
    logic [15:0] pw;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0: begin id = 4'($urandom_range(1, NU)); pw = bank_pw(int'(id)); end
        1: make_wrong(id, pw);
        default: begin
          id = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(NU + 1, 15));
          pw = 16'($urandom_range(0, 65535));
        end
      endcase
      attempt("random", id, pw, $urandom_range(1, 6), 0);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [3:0] id;
    logic [15:0] pw;
    logic seen;
    attempt("hold20", 4'd4, bank_pw(4), 20, 0);
    // Reset mid-GRANT with the button still held.
    enter = 1'b1; user_id = 4'd1; {digit4, digit3, digit2, digit1} = bank_pw(1);
    repeat (3) @(negedge clk);
    n_checks++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL mid_grant_unlock got %b exp 1", unlock); end
    reset = 1'b1;
    #1;
    $display("reset mid-grant unlock=%b busy=%b", unlock, busy);
    n_checks++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL abort_unlock got %b exp 0", unlock); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    model_fail = 0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0 || unlock !== 1'b0 || deny !== 1'b0) seen = 1'b1;
    end
    $display("held enter after reset release activity=%b", seen);
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL held_enter_after_reset got %b exp 0", seen); end
    enter = 1'b0;
    @(negedge clk);
    attempt("after_reset", 4'd1, bank_pw(1), 1, 0);
    // Reset mid-LOCKOUT must clear the failure count.
    make_wrong(id, pw); attempt("abort_wrong1", id, pw, 1, 0);
    make_wrong(id, pw); attempt("abort_wrong2", id, pw, 1, 0);
    make_wrong(id, pw);
    enter = 1'b1; user_id = id; {digit4, digit3, digit2, digit1} = pw;
    @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (locked !== 1'b1 || fail_cnt !== 2'd3) begin n_fail++; $display("FAIL mid_lockout got locked=%b fail_cnt=%0d exp locked=1 fail_cnt=3", locked, fail_cnt); end
    reset = 1'b1;
    #1;
    $display("reset mid-lockout locked=%b fail_cnt=%0d", locked, fail_cnt);
    n_checks++; if (locked !== 1'b0 || fail_cnt !== 2'd0) begin n_fail++; $display("FAIL abort_lockout got locked=%b fail_cnt=%0d exp locked=0 fail_cnt=0", locked, fail_cnt); end
    @(negedge clk);
    reset = 1'b0;
    model_fail = 0;
    repeat (2) @(negedge clk);
    attempt("post_lock_reset_deny", 4'd2, bank_pw(3), 1, 0);
  endtask

  initial begin
    for (int u = 1; u <= NU; u++) stored_pw[16*u-1 -: 16] = bank_pw(u);
    test_reset();
    test_grant();
    test_deny();
    test_lockout();
    test_invalid_id();
    test_recover();
    test_random();
    test_hold_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
